// File: rtl/rv_isa_pkg.sv
// RV32I encoding constants and a pure encode function shared by the lab's encoder/decoder.
// Latency: none (combinational helper only).
// Backpressure: n/a.
// Contents: opcode, op-class, ALUOp, funct3/funct7 constants, NOP word,
//           enc_t {legal, word} and rv_encode().
package rv_isa_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // Op classes as presented by the decoder
  localparam logic [2:0] CLS_R  = 3'd0;
  localparam logic [2:0] CLS_I  = 3'd1;
  localparam logic [2:0] CLS_LW = 3'd2;
  localparam logic [2:0] CLS_SW = 3'd3;
  localparam logic [2:0] CLS_BR = 3'd4;

  // ALUOp codes, identical to the decoder's
  localparam logic [2:0] ALU_SUB = 3'b000;
  localparam logic [2:0] ALU_ADD = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLL = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_SLT = 3'b110;

  // funct3 / funct7
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic        legal;
    logic [31:0] word;
  } enc_t;

  // Pure encoder. Illegal combinations return legal=0 and word=0.
  function automatic enc_t rv_encode(input logic [2:0]  opclass,
                                     input logic [2:0]  aluop,
                                     input logic [2:0]  brcond,
                                     input logic [4:0]  rd,
                                     input logic [4:0]  rs1,
                                     input logic [4:0]  rs2,
                                     input logic [12:0] imm);
    enc_t       r;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       alu_ok;
    r      = '0;
    f3     = F3_ADD;
    f7     = F7_BASE;
    alu_ok = 1'b1;
    case (aluop)
      ALU_ADD: f3 = F3_ADD;
      ALU_SUB: begin f3 = F3_ADD; f7 = F7_SUB; end
      ALU_AND: f3 = F3_AND;
      ALU_OR:  f3 = F3_OR;
      ALU_SLL: f3 = F3_SLL;
      ALU_SRL: f3 = F3_SRL;
      ALU_SLT: f3 = F3_SLT;
      default: alu_ok = 1'b0;
    endcase
    case (opclass)
      CLS_R: begin
        r.legal = alu_ok;
        r.word  = {f7, rs2, rs1, f3, rd, OPC_R};
      end
      CLS_I: begin
        // There is no subi; immediate shifts carry a 5-bit shamt with a zero upper field.
        r.legal = alu_ok && (aluop != ALU_SUB);
        if (aluop == ALU_SLL || aluop == ALU_SRL)
          r.word = {7'b0, imm[4:0], rs1, f3, rd, OPC_I};
        else
          r.word = {imm[11:0], rs1, f3, rd, OPC_I};
      end
      CLS_LW: begin
        r.legal = 1'b1;
        r.word  = {imm[11:0], rs1, F3_W, rd, OPC_LOAD};
      end
      CLS_SW: begin
        r.legal = 1'b1;
        r.word  = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OPC_STORE};
      end
      CLS_BR: begin
        r.legal = (brcond == F3_BEQ) || (brcond == F3_BNE) ||
                  (brcond == F3_BLT) || (brcond == F3_BGE);
        r.word  = {imm[12], imm[10:5], rs2, rs1, brcond, imm[4:1], imm[11], OPC_BRANCH};
      end
      default: r.legal = 1'b0;
    endcase
    if (!r.legal) r.word = '0;
    return r;
  endfunction

endpackage

// File: rtl/rv_sync_fifo.sv
// Generic synchronous FIFO, DEPTH (power of two, >= 2) x WIDTH, head visible combinationally.
// Latency: a push at edge N is visible at head after edge N.
// Backpressure: push ignored when full, pop ignored when empty; caller gates on full/empty.
// Ports: clk, rst (async active-high), push/push_data, pop, head, full, empty.
module rv_sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  // Pointers carry one extra wrap bit to tell full from empty.
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Storage is reset so the head reads 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= push_data;
        wr_ptr              <= wr_ptr + PTR_ONE;
      end
      if (pop && !empty) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/rv_inst_encoder.sv
// Packs decoded RV32I ops into instruction words and streams them with a running byte address.
// Latency: op accepted at edge N appears on out_* after edge N (no same-cycle bypass).
// Backpressure: in_ready = FIFO not full; out_* held until out_ready.
// Ports: clk, rst (async active-high); in_valid/in_ready + op fields; out_valid/out_ready,
//        out_instr, out_addr; err_pulse, err_count.
// Build option: RV_ENC_NOP_ON_ILLEGAL_EN -- illegal ops push a NOP instead of being dropped.
module rv_inst_encoder
  import rv_isa_pkg::*;
#(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_opclass,
  input  logic [2:0]       in_aluop,
  input  logic [2:0]       in_brcond,
  input  logic [4:0]       in_rd,
  input  logic [4:0]       in_rs1,
  input  logic [4:0]       in_rs2,
  input  logic [12:0]      in_imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic [31:0]      out_addr,
  output logic             err_pulse,
  output logic [ERR_W-1:0] err_count
);

  localparam logic [ERR_W-1:0] ERR_ONE = 1;
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  enc_t        enc;
  logic        full;
  logic        empty;
  logic        accept;
  logic        push;
  logic [31:0] push_data;
  logic        pop;

  assign enc      = rv_encode(in_opclass, in_aluop, in_brcond, in_rd, in_rs1, in_rs2, in_imm);
  assign in_ready = !full;
  assign accept   = in_valid && in_ready;
  assign pop      = out_valid && out_ready;

  // Illegal ops always consume the handshake; only what gets queued differs.
`ifdef RV_ENC_NOP_ON_ILLEGAL_EN
  assign push      = accept;
  assign push_data = enc.legal ? enc.word : NOP_INSTR;
`else
  assign push      = accept && enc.legal;
  assign push_data = enc.word;
`endif

  rv_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (out_instr),
    .full      (full),
    .empty     (empty)
  );

  assign out_valid = !empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_addr  <= BASE_ADDR;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      if (pop) out_addr <= out_addr + 32'd4;
      err_pulse <= accept && !enc.legal;
      if (accept && !enc.legal && err_count != ERR_MAX)
        err_count <= err_count + ERR_ONE;
    end
  end

endmodule

// File: tb/tb_rv_inst_encoder.sv
`timescale 1ns/1ps
module tb_rv_inst_encoder;

  localparam int          DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          ERR_W = 8;
`ifdef RV_ENC_NOP_ON_ILLEGAL_EN
  localparam bit NOP_EN = 1'b1;
`else
  localparam bit NOP_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [2:0]       in_opclass = '0;
  logic [2:0]       in_aluop = '0;
  logic [2:0]       in_brcond = '0;
  logic [4:0]       in_rd = '0;
  logic [4:0]       in_rs1 = '0;
  logic [4:0]       in_rs2 = '0;
  logic [12:0]      in_imm = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [31:0]      out_instr;
  logic [31:0]      out_addr;
  logic             err_pulse;
  logic [ERR_W-1:0] err_count;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  rv_inst_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opclass(in_opclass), .in_aluop(in_aluop), .in_brcond(in_brcond),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_addr(out_addr),
    .err_pulse(err_pulse), .err_count(err_count)
  );

  // Reference encoding built from field positions with plain arithmetic. Returns {legal, word}.
  function automatic logic [32:0] ref_enc(input longint cls, input longint alu, input longint brc,
                                          input longint rd, input longint rs1, input longint rs2,
                                          input longint imm);
    longint f3, w;
    case (alu)
      0, 1: f3 = 0;
      2: f3 = 7;
      3: f3 = 6;
      4: f3 = 1;
      5: f3 = 5;
      6: f3 = 2;
      default: f3 = -1;
    endcase
    case (cls)
      0: begin
        if (f3 < 0) return 33'd0;
        w = ((alu == 0) ? 32 : 0) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h33;
      end
      1: begin
        if (f3 < 0 || alu == 0) return 33'd0;
        if (alu == 4 || alu == 5) w = (imm % 32) * 2**20;
        else                      w = (imm % 4096) * 2**20;
        w = w + rs1 * 2**15 + f3 * 2**12 + rd * 2**7 + 'h13;
      end
      2: w = (imm % 4096) * 2**20 + rs1 * 2**15 + 2 * 2**12 + rd * 2**7 + 'h03;
      3: w = ((imm % 4096) / 32) * 2**25 + rs2 * 2**20 + rs1 * 2**15 + 2 * 2**12 + (imm % 32) * 2**7 + 'h23;
      4: begin
        if (!(brc == 0 || brc == 1 || brc == 4 || brc == 5)) return 33'd0;
        w = ((imm / 4096) % 2) * 2**31 + ((imm / 32) % 64) * 2**25 + rs2 * 2**20 + rs1 * 2**15 +
            brc * 2**12 + ((imm / 2) % 16) * 2**8 + ((imm / 2048) % 2) * 2**7 + 'h63;
      end
      default: return 33'd0;
    endcase
    return {1'b1, w[31:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  // Transaction-level model: queue of pending words, address and error counters.
  logic [31:0] mq[$];
  logic [31:0] m_addr = BASE;
  logic        m_err  = 1'b0;
  int          m_cnt  = 0;

  always @(posedge clk or posedge rst) begin
    logic [32:0] e;
    bit acc, pop;
    if (rst) begin
      mq.delete();
      m_addr = BASE;
      m_err  = 1'b0;
      m_cnt  = 0;
    end else begin
      acc = in_valid && (mq.size() < DEPTH);
      pop = out_ready && (mq.size() > 0);
      e   = ref_enc(in_opclass, in_aluop, in_brcond, in_rd, in_rs1, in_rs2, in_imm);
      m_err = acc && !e[32];
      if (m_err && m_cnt < 2**ERR_W - 1) m_cnt++;
      if (pop) begin
        void'(mq.pop_front());
        m_addr = m_addr + 32'd4;
      end
      if (acc && e[32]) mq.push_back(e[31:0]);
      else if (acc && NOP_EN) mq.push_back(32'h0000_0013);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      check("mon_in_ready", {31'd0, in_ready}, {31'd0, mq.size() < DEPTH});
      check("mon_out_valid", {31'd0, out_valid}, {31'd0, mq.size() > 0});
      if (mq.size() > 0) check("mon_out_instr", out_instr, mq[0]);
      check("mon_out_addr", out_addr, m_addr);
      check("mon_err_pulse", {31'd0, err_pulse}, {31'd0, m_err});
      check("mon_err_count", {24'd0, err_count}, m_cnt);
    end
  end

  // All tasks below are entered and left just after a rising edge.
  task automatic set_op(input logic [2:0] c, input logic [2:0] a, input logic [2:0] b,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [12:0] im);
    in_opclass = c; in_aluop = a; in_brcond = b;
    in_rd = d; in_rs1 = s1; in_rs2 = s2; in_imm = im;
  endtask

  task automatic offer(input string tag);
    int n = 0;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_accept"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] w, input logic [31:0] a);
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    check({tag, "_instr"}, out_instr, w);
    check({tag, "_addr"}, out_addr, a);
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] e;
    #2 rst = 1'b1;
    #1 mon_en = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_instr", out_instr, 32'd0);
    check("rst_out_addr", out_addr, BASE);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_err_count", {24'd0, err_count}, 32'd0);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // R add x3, x1, x2
    set_op(3'd0, 3'b001, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    offer("r_add");
    pop_check("r_add", 32'h002081B3, BASE);

    // sub / lw / sw held, then drained in order
    do_reset();
    set_op(3'd0, 3'b000, 3'd0, 5'd5, 5'd6, 5'd7, 13'd0);
    offer("r_sub");
    set_op(3'd2, 3'd0, 3'd0, 5'd10, 5'd2, 5'd0, 13'd8);
    offer("lw");
    set_op(3'd3, 3'd0, 3'd0, 5'd0, 5'd2, 5'd10, 13'd8);
    offer("sw");
    pop_check("r_sub", 32'h407302B3, BASE);
    pop_check("lw", 32'h00812503, BASE + 32'd4);
    pop_check("sw", 32'h00A12423, BASE + 32'd8);

    // beq x1, x2, -4
    do_reset();
    set_op(3'd4, 3'd0, 3'b000, 5'd0, 5'd1, 5'd2, 13'h1FFC);
    offer("beq");
    pop_check("beq", 32'hFE208EE3, BASE);

    // Fill to DEPTH with out_ready low, then drain, then the remaining two
    do_reset();
    for (int k = 0; k < DEPTH; k++) begin
      set_op(3'd1, 3'b001, 3'd0, 5'(k + 1), 5'd0, 5'd0, 13'(k + 1));
      offer("fill");
    end
    set_op(3'd1, 3'b001, 3'd0, 5'd9, 5'd0, 5'd0, 13'd9);
    in_valid = 1'b1;
    @(negedge clk);
    check("full_in_ready", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("full_in_ready_hold", {31'd0, in_ready}, 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < DEPTH; k++) begin
      e = ref_enc(1, 1, 0, k + 1, 0, 0, k + 1);
      pop_check("drain", e[31:0], BASE + 32'(4 * k));
    end
    set_op(3'd1, 3'b001, 3'd0, 5'd9, 5'd0, 5'd0, 13'd9);
    offer("late0");
    set_op(3'd1, 3'b001, 3'd0, 5'd10, 5'd0, 5'd0, 13'd10);
    offer("late1");
    pop_check("late0", 32'h00900493, BASE + 32'h10);
    pop_check("late1", 32'h00A00513, BASE + 32'h14);

    // Illegal I-ALU aluop 000
    set_op(3'd1, 3'b000, 3'd0, 5'd1, 5'd1, 5'd0, 13'd5);
    offer("illegal");
    @(negedge clk);
    check("ill_err_pulse", {31'd0, err_pulse}, 32'd1);
    check("ill_err_count", {24'd0, err_count}, 32'd1);
    check("ill_out_valid", {31'd0, out_valid}, {31'd0, NOP_EN});
    @(negedge clk);
    check("ill_err_pulse_clear", {31'd0, err_pulse}, 32'd0);
    @(posedge clk);
    #1;
    if (NOP_EN) pop_check("ill_nop", 32'h0000_0013, BASE + 32'h18);

    // Reset with three words queued
    set_op(3'd2, 3'd0, 3'd0, 5'd4, 5'd3, 5'd0, 13'd12);
    for (int k = 0; k < 3; k++) offer("preq");
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_out_addr", out_addr, BASE);
    check("mid_rst_err_count", {24'd0, err_count}, 32'd0);
    check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst = 1'b0;
    set_op(3'd0, 3'b001, 3'd0, 5'd3, 5'd1, 5'd2, 13'd0);
    offer("post_rst");
    pop_check("post_rst", 32'h002081B3, BASE);

    // Saturate the error counter
    out_ready = 1'b1;
    set_op(3'd7, 3'd0, 3'd0, 5'd0, 5'd0, 5'd0, 13'd0);
    in_valid = 1'b1;
    repeat (2**ERR_W + 4) @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("err_saturate", {24'd0, err_count}, 32'h0000_00FF);
    @(posedge clk);
    #1;

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      in_valid   = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 9) < 6);
      in_opclass = 3'($urandom_range(0, 7));
      in_aluop   = 3'($urandom);
      in_brcond  = 3'($urandom);
      in_rd      = 5'($urandom);
      in_rs1     = 5'($urandom);
      in_rs2     = 5'($urandom);
      in_imm     = 13'($urandom);
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (DEPTH + 2) @(posedge clk);
    #1;
    @(negedge clk);
    check("drain_empty", {31'd0, out_valid}, 32'd0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rv_inst_encoder.md
Name: rv_inst_encoder

Overview:
- Inverse of the core's instruction decoder: takes decoded operation fields (op class, ALUOp, registers, immediate) and packs them into 32-bit RV32I instruction words.
- Encoded words go into a small FIFO and stream out over valid/ready with an auto-incrementing word address.
- Used by the lab test harness and boot loader to build instruction-memory images from symbolic ops.
- Supported subset matches the decoder exactly: R-ALU, I-ALU, LW, SW, BEQ/BNE/BLT/BGE.

Parameters:
- DEPTH, 4: FIFO entries; power of two, >= 2.
- BASE_ADDR, 32'h0000_0000: byte address of the first emitted word.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  source presents an op.
- in_ready  out  1  block accepts the op this cycle.
- in_opclass  in  3  0=R, 1=I-ALU, 2=LW, 3=SW, 4=BRANCH; 5-7 illegal.
- in_aluop  in  3  ALUOp code: 000 sub, 001 add, 010 and, 011 or, 100 sll, 101 srl, 110 slt.
- in_brcond  in  3  branch funct3.
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  13  immediate; low 12 bits for I/LW/SW; all 13 bits for branch, bit0 ignored.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  sink accepts the head word.
- out_instr  out  32  encoded word.
- out_addr  out  32  byte address of out_instr.
- err_pulse  out  1  one-cycle flag for an illegal accepted op.
- err_count  out  ERR_W  saturating count of illegal ops.

Behaviour:
- Reset values: out_valid=0, out_instr=0, out_addr=BASE_ADDR, err_pulse=0, err_count=0, FIFO empty, in_ready=1.
- in_ready = !full. Accept occurs when in_valid && in_ready.
- Encoding is combinational on the inputs; an accepted legal op is written to the FIFO tail on that edge.
- Latency: op accepted at edge N into an empty FIFO gives out_valid=1 after edge N. No same-cycle bypass.
- R (opcode 0110011), funct7/funct3 by ALUOp: 001 -> 0000000/000; 000 -> 0100000/000; 010 -> 0/111; 011 -> 0/110; 100 -> 0/001; 101 -> 0/101; 110 -> 0/010. ALUOp 111 is illegal.
- I-ALU (opcode 0010011), imm in [31:20]: 001 -> 000; 010 -> 111; 011 -> 110; 110 -> 010; 100 -> 001 and 101 -> 101 with [31:25]=0 and shamt=in_imm[4:0]. ALUOp 000 and 111 are illegal.
- LW: opcode 0000011, funct3 010, imm in [31:20].
- SW: opcode 0100011, funct3 010, imm[11:5] in [31:25], imm[4:0] in [11:7], rs2 in [24:20].
- BRANCH: opcode 1100011, funct3=in_brcond; only 000/001/100/101 are legal. Bit mapping: [31]=imm[12], [30:25]=imm[10:5], [11:8]=imm[4:1], [7]=imm[11].
- Unused fields are 0.
- Illegal op: still accepted (consumes the handshake) but not pushed. err_pulse=1 on the following cycle; err_count increments, saturating at all-ones.
- Output handshake: on out_valid && out_ready the head pops and out_addr += 4, wrapping mod 2^32.
- Full and popping in the same cycle: in_ready stays 0, so no write that cycle.
- Empty: out_instr holds its last value and is don't-care.
- Simultaneous push and pop when neither full nor empty: both happen, occupancy unchanged.
- Reset mid-stream: FIFO flushes immediately; all outputs return to reset values asynchronously.

Optional Feature:
- Macro: RV_ENC_NOP_ON_ILLEGAL_EN.
- Defined: illegal ops push NOP 32'h0000_0013 (addi x0,x0,0) so the address stream stays dense. err_pulse and err_count still update.
- Undefined: illegal ops are dropped as described in Behaviour.

Decomposition:
- Shared package rv_isa_pkg: opcode constants, opclass codes, ALUOp codes (identical to the decoder's), funct3/funct7 constants, NOP constant, and a pure encode function returning {legal, word}.
- One sub-module: rv_sync_fifo (DEPTH, width 32; push/pop/full/empty). It is reusable across the lab.

Test Plan:
- R add rd=3 rs1=1 rs2=2 -> out_instr 32'h002081B3, out_addr 0x0.
- R sub rd=5 rs1=6 rs2=7, then LW rd=10 rs1=2 imm=8, then SW rs2=10 rs1=2 imm=8 -> 32'h407302B3, 32'h00812503, 32'h00A12423 at addresses 0x0/0x4/0x8.
- BRANCH brcond=000 rs1=1 rs2=2 imm=13'h1FFC (-4) -> 32'hFE208EE3.
- DEPTH=4, out_ready=0, 6 ops offered -> in_ready low after 4 accepts; release out_ready -> 4 words in order at 0x0, 0x4, 0x8, 0xC, then remaining 2 accepted.
- I-ALU aluop=000 -> no push, err_pulse high for exactly 1 cycle, err_count=1. With macro defined -> 32'h00000013 emitted instead.
- rst asserted with 3 words queued -> out_valid=0 immediately, out_addr=BASE_ADDR, err_count=0; after release, the next op is emitted at BASE_ADDR.
